// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment digit scanner
package seg_pkg;
    typedef enum logic {BLANK = 1'b0, SCAN = 1'b1} seg_state_e;
    localparam int DEF_NUM_DIGITS = 4;
    localparam logic [31:0] AN_OFF = '1;
endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: self-reloading down-counter, done pulses on the last cycle of each i_len-cycle interval
//   clk, rst_n : clock, async active-low reset
//   i_len      : interval length in cycles (>=1), sampled when the counter reloads
//   o_done     : high during the final cycle of the current interval
module seg_slot_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_len,
    output logic         o_done
);
    logic [W-1:0] r_cnt;
    // zero means "interval just started": reload with the remaining length
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= (r_cnt == '0) ? i_len - W'(1) : r_cnt - W'(1);
    assign o_done = (r_cnt == '0) ? (i_len == W'(1)) : (r_cnt == W'(1));
endmodule

// File: rtl/seg_digit_scanner.sv
// seg_digit_scanner: time-multiplexed, double-buffered hex digit scanner with inter-digit blanking
//   clk, rst_n  : clock, async active-low reset
//   value, load : packed nibbles (digit 0 = LSB) and capture strobe
//   digit_en    : per-digit enable, sampled at the start of each digit's scan
//   hex_out     : nibble for the seven-segment decoder
//   an          : active-low anodes, one-hot-low or all ones
//   pending     : a captured value waits for the next frame boundary
//   frame_tick  : one-cycle pulse on the frame boundary cycle
module seg_digit_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [3:0]              hex_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_tick
);
    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    seg_state_e              r_state, w_state_nxt;
    logic [IW-1:0]           r_idx, w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] r_disp, r_pval, w_disp_nxt;
    logic                    r_pending;
    logic [3:0]              r_hex;
    logic [NUM_DIGITS-1:0]   r_an, w_an_nxt;
    logic [CW-1:0]           w_len;
    logic                    w_done, w_boundary;

    assign w_len = (r_state == SCAN) ? CW'(REFRESH_DIV) : CW'(BLANK_CYCLES);

    seg_slot_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_len  (w_len),
        .o_done (w_done)
    );

    assign w_boundary = (r_state == SCAN) && w_done && (r_idx == IW'(NUM_DIGITS - 1));

    always_comb begin
        w_state_nxt = w_done ? ((r_state == BLANK) ? SCAN : BLANK) : r_state;
        w_idx_nxt   = (w_done && r_state == SCAN) ?
                      ((r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1) : r_idx;
        // a load on the boundary itself bypasses the pending buffer
        w_disp_nxt  = w_boundary ? (load ? value : (r_pending ? r_pval : r_disp)) : r_disp;
        w_an_nxt    = !w_done ? r_an :
                      (r_state == SCAN) ? AN_OFF[NUM_DIGITS-1:0] :
                      digit_en[r_idx] ? ~(NUM_DIGITS'(1) << r_idx) : AN_OFF[NUM_DIGITS-1:0];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state   <= BLANK;
            r_idx     <= '0;
            r_disp    <= '0;
            r_pval    <= '0;
            r_pending <= 1'b0;
            r_hex     <= 4'h0;
            r_an      <= AN_OFF[NUM_DIGITS-1:0];
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_disp    <= w_disp_nxt;
            r_pval    <= (load && !w_boundary) ? value : r_pval;
            r_pending <= w_boundary ? 1'b0 : (load ? 1'b1 : r_pending);
            // the nibble is chosen on BLANK entry so it settles before the anode turns on
            r_hex     <= (w_done && r_state == SCAN) ? w_disp_nxt[4*w_idx_nxt +: 4] : r_hex;
            r_an      <= w_an_nxt;
        end

    assign hex_out    = r_hex;
    assign an         = r_an;
    assign pending    = r_pending;
    assign frame_tick = w_boundary;
endmodule

// File: tb/tb_seg_digit_scanner.sv
// tb_seg_digit_scanner: randomized self-checking bench against a slot/frame arithmetic model
module tb_seg_digit_scanner;
    localparam int N = 4, R = 4, B = 2, S = B + R, F = N * S;

    logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  hex_out, an;
    logic        pending, frame_tick;

    int          n_vec = 0, n_err = 0, t = 0;
    logic [15:0] m_disp, m_pval;
    logic        m_pend, m_en;

    seg_digit_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .digit_en(digit_en),
        .hex_out(hex_out), .an(an), .pending(pending), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d: got %0h, expected %0h", nm, t, act, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; m_disp = '0; m_pval = '0; m_pend = 1'b0; m_en = 1'b0;
    endtask

    // cycle t: slot s = (t mod F)/S, phase q = t mod S; blank while q < B
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] en);
        int q, s;
        logic bnd;
        logic [3:0] e_an, e_hex;
        @(negedge clk);
        q = t % S;
        s = (t % F) / S;
        bnd = ((t % F) == F - 1);
        e_an = (q < B || !m_en) ? 4'hF : ~(4'b0001 << s);
        e_hex = 4'(m_disp >> (4 * s));
        chk("an", an, e_an);
        chk("hex_out", hex_out, e_hex);
        chk("pending", pending, m_pend);
        chk("frame_tick", frame_tick, bnd);
        load = ld; value = v; digit_en = en;
        if (q == B - 1) m_en = en[s];
        if (bnd) begin
            if (ld) m_disp = v;
            else if (m_pend) m_disp = m_pval;
            m_pend = 1'b0;
        end else if (ld) begin
            m_pval = v;
            m_pend = 1'b1;
        end
        t++;
    endtask

    task automatic pin(input logic [3:0] ea, input logic [3:0] eh, input logic ep, input logic et);
        @(posedge clk); #1;
        chk("pin_an", an, ea);
        chk("pin_hex", hex_out, eh);
        chk("pin_pending", pending, ep);
        chk("pin_tick", frame_tick, et);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_hex", hex_out, 4'h0);
        chk("rst_pending", pending, 1'b0);
        chk("rst_tick", frame_tick, 1'b0);
        @(posedge clk); #2 rst_n = 1'b1;
        // first anode exactly B cycles after release
        step(1'b0, '0, 4'hF);
        pin(4'hF, 4'h0, 1'b0, 1'b0);
        step(1'b0, '0, 4'hF);
        pin(4'hE, 4'h0, 1'b0, 1'b0);
        while (t < 23) step(1'b0, '0, 4'hF);
        pin(4'h7, 4'h0, 1'b0, 1'b1);
        // load on the boundary goes straight to display
        step(1'b1, 16'h1234, 4'hF);
        pin(4'hF, 4'h4, 1'b0, 1'b0);
        while (t < 26) step(1'b0, '0, 4'hF);
        pin(4'hE, 4'h4, 1'b0, 1'b0);
        // mid-frame load waits for the boundary
        while (t < 30) step(1'b0, '0, 4'hF);
        step(1'b1, 16'hABCD, 4'hF);
        step(1'b0, '0, 4'hF);
        pin(4'hD, 4'h3, 1'b1, 1'b0);
        while (t < 50) step(1'b0, '0, 4'hF);
        pin(4'hE, 4'hD, 1'b0, 1'b0);
        // disabled digits still consume their slots
        while (t < 80) step(1'b0, '0, 4'b0101);
        pin(4'hF, 4'hC, 1'b0, 1'b0);
        // last load before the boundary wins
        while (t < 100) step(1'b0, '0, 4'hF);
        step(1'b1, 16'h1111, 4'hF);
        while (t < 110) step(1'b0, '0, 4'hF);
        step(1'b1, 16'h2222, 4'hF);
        while (t < 122) step(1'b0, '0, 4'hF);
        pin(4'hE, 4'h2, 1'b0, 1'b0);
        repeat (20 * F) step($urandom_range(0, 9) == 0, 16'($urandom), 4'($urandom));
        // async reset in the middle of digit 2's scan
        while ((t % F) != 15) step(1'b0, 16'($urandom), 4'hF);
        @(posedge clk); #1;
        chk("pre_rst_an", an, 4'b1011);
        #1 rst_n = 1'b0;
        #1 chk("async_an", an, 4'hF);
        load = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst2_hex", hex_out, 4'h0);
            chk("rst2_pending", pending, 1'b0);
            chk("rst2_tick", frame_tick, 1'b0);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        model_reset();
        step(1'b0, '0, 4'hF);
        step(1'b0, '0, 4'hF);
        pin(4'hE, 4'h0, 1'b0, 1'b0);
        repeat (2 * F) step(1'b0, '0, 4'hF);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
